// File: rtl/zpu_trace_emitter.sv
// ZPU debug trace producer: PC-triggered capture of retired instructions into a show-ahead FIFO
// drained over a valid/ready port. Define TRACE_OVF_MARK_EN to insert drop-marker records.
module zpu_trace_emitter #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              retire_valid_i,
  input  logic [31:0]       retire_pc_i,
  input  logic [31:0]       retire_sp_i,
  input  logic [31:0]       retire_tos_i,
  input  logic [31:0]       retire_nos_i,
  input  logic [7:0]        retire_inst_i,
  input  logic              trig_en_i,
  input  logic [31:0]       trig_start_pc_i,
  input  logic [31:0]       trig_stop_pc_i,
  input  logic              dbg_ready_i,
  output logic [136:0]      dbg_o,
  output logic [15:0]       ovf_cnt_o,
  output logic [1:0]        state_o,
  output logic [ADDR_W:0]   level_o
);

  // Handshake: a record transfers on a clock edge where dbg_o[136] and dbg_ready_i are both high;
  // while dbg_o[136] is high and dbg_ready_i is low, dbg_o holds its value.

  localparam int REC_W = 136;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_TRACING = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   capture;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = trig_en_i ? S_ARMED : S_TRACING;
      S_ARMED:   if (retire_valid_i && retire_pc_i == trig_start_pc_i) state_d = S_TRACING;
      S_TRACING: if (retire_valid_i && trig_en_i && retire_pc_i == trig_stop_pc_i) state_d = S_DONE;
      S_DONE:    if (!trig_en_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // The start-PC retire itself is captured, so ARMED captures on a match.
  always_comb begin
    capture = 1'b0;
    case (state_q)
      S_ARMED:   capture = retire_valid_i && (retire_pc_i == trig_start_pc_i);
      S_TRACING: capture = retire_valid_i;
      default:   capture = 1'b0;
    endcase
  end

  assign state_o = state_q;

  logic [REC_W-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   wcnt_q, rcnt_q, level;
  logic [ADDR_W+1:0] free;
  logic              valid, pop, push_rec, drop;
  logic [REC_W-1:0]  rec;
  logic [ADDR_W-1:0] wptr, rptr, rec_idx;

  assign level = wcnt_q - rcnt_q;
  assign valid = (level != '0);
  assign pop   = valid && dbg_ready_i;
  assign wptr  = wcnt_q[ADDR_W-1:0];
  assign rptr  = rcnt_q[ADDR_W-1:0];
  assign rec   = {retire_inst_i, retire_nos_i, retire_tos_i, retire_sp_i, retire_pc_i};
  // A pop in the same cycle frees its slot for this cycle's writes.
  assign free  = (ADDR_W+2)'(DEPTH) - {1'b0, level} + {{(ADDR_W+1){1'b0}}, pop};

`ifdef TRACE_OVF_MARK_EN
  logic        pend_q, push_mark;
  logic [15:0] drops_q;
  logic [REC_W-1:0] mark;

  assign mark = {8'hFF, 32'h0, 32'h0, 16'h0, drops_q, 32'hFFFF_FFFF};

  always_comb begin
    push_rec  = 1'b0;
    push_mark = 1'b0;
    if (pend_q) begin
      if (capture) begin
        push_mark = (free >= (ADDR_W+2)'(2));
        push_rec  = push_mark;
      end else begin
        push_mark = (free != '0);
      end
    end else begin
      push_rec = capture && (free != '0);
    end
    drop    = capture && !push_rec;
    rec_idx = push_mark ? wptr + ADDR_W'(1) : wptr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      drops_q <= 16'h0;
    end else if (push_mark) begin
      pend_q  <= 1'b0;
      drops_q <= 16'h0;
    end else if (drop) begin
      pend_q  <= 1'b1;
      if (drops_q != 16'hFFFF) drops_q <= drops_q + 16'h1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_mark) mem[wptr] <= mark;
    if (push_rec)  mem[rec_idx] <= rec;
  end

  always_ff @(posedge clk) begin
    if (rst) wcnt_q <= '0;
    else     wcnt_q <= wcnt_q + (ADDR_W+1)'(push_rec) + (ADDR_W+1)'(push_mark);
  end
`else
  always_comb begin
    push_rec = capture && (free != '0);
    drop     = capture && !push_rec;
    rec_idx  = wptr;
  end

  always_ff @(posedge clk) begin
    if (push_rec) mem[rec_idx] <= rec;
  end

  always_ff @(posedge clk) begin
    if (rst) wcnt_q <= '0;
    else     wcnt_q <= wcnt_q + (ADDR_W+1)'(push_rec);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)      rcnt_q <= '0;
    else if (pop) rcnt_q <= rcnt_q + (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                              ovf_cnt_o <= 16'h0;
    else if (drop && ovf_cnt_o != 16'hFFFF) ovf_cnt_o <= ovf_cnt_o + 16'h1;
  end

  assign dbg_o   = {valid, valid ? mem[rptr] : {REC_W{1'b0}}};
  assign level_o = level;

endmodule

// File: tb/tb_zpu_trace_emitter.sv
// Directed bench for zpu_trace_emitter: expected records queued at retire, checked by a monitor on pop.
module tb_zpu_trace_emitter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         retire_valid_i = 1'b0;
  logic [31:0]  retire_pc_i = '0, retire_sp_i = '0, retire_tos_i = '0, retire_nos_i = '0;
  logic [7:0]   retire_inst_i = '0;
  logic         trig_en_i = 1'b0;
  logic [31:0]  trig_start_pc_i = '0, trig_stop_pc_i = '0;
  logic         dbg_ready_i = 1'b0;
  logic [136:0] dbg_o;
  logic [15:0]  ovf_cnt_o;
  logic [1:0]   state_o;
  logic [3:0]   level_o;

  logic [135:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  zpu_trace_emitter #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .retire_valid_i(retire_valid_i), .retire_pc_i(retire_pc_i), .retire_sp_i(retire_sp_i),
    .retire_tos_i(retire_tos_i), .retire_nos_i(retire_nos_i), .retire_inst_i(retire_inst_i),
    .trig_en_i(trig_en_i), .trig_start_pc_i(trig_start_pc_i), .trig_stop_pc_i(trig_stop_pc_i),
    .dbg_ready_i(dbg_ready_i), .dbg_o(dbg_o), .ovf_cnt_o(ovf_cnt_o),
    .state_o(state_o), .level_o(level_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [135:0] mk_rec(input logic [31:0] pc);
    logic [31:0] sp, tos, nos;
    sp  = pc + 32'h1000;
    tos = pc ^ 32'hA5A5_0000;
    nos = ~pc;
    return {pc[7:0], nos, tos, sp, pc};
  endfunction

  function automatic logic [135:0] mk_mark(input logic [15:0] drops);
    return {8'hFF, 32'h0, 32'h0, 16'h0, drops, 32'hFFFF_FFFF};
  endfunction

  // driver tasks
  task automatic retire(input logic [31:0] pc, input bit expect_out);
    retire_valid_i = 1'b1;
    retire_pc_i    = pc;
    retire_sp_i    = pc + 32'h1000;
    retire_tos_i   = pc ^ 32'hA5A5_0000;
    retire_nos_i   = ~pc;
    retire_inst_i  = pc[7:0];
    if (expect_out) exp_q.push_back(mk_rec(pc));
    @(posedge clk); #1;
    retire_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // scoreboard monitor: a transfer happens at the next rising edge
  always @(negedge clk) begin
    if (!rst && dbg_o[136] && dbg_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got %h expected none", dbg_o[135:0]);
      end else begin
        check("record", dbg_o[135:0], exp_q.pop_front());
      end
    end
  end

  initial begin
    // 1: reset state and free-run latency
    trig_en_i = 1'b0;
    dbg_ready_i = 1'b1;
    do_reset();
    check("reset_dbg", dbg_o[135:0], 136'h0);
    check("reset_valid", 136'(dbg_o[136]), 136'h0);
    check("reset_level", 136'(level_o), 136'h0);
    check("reset_ovf", 136'(ovf_cnt_o), 136'h0);
    check("reset_state", 136'(state_o), 136'h0);
    idle(1);
    check("freerun_state", 136'(state_o), 136'h2);
    for (int i = 0; i < 3; i++) begin
      retire(32'h10 + 32'(i), 1'b1);
      check("latency_valid", 136'(dbg_o[136]), 136'h1);
      check("latency_pc", 136'(dbg_o[31:0]), 136'(32'h10 + 32'(i)));
    end
    idle(2);
    check("t1_empty", 136'(level_o), 136'h0);

    // 2: start/stop trigger
    trig_en_i = 1'b1;
    trig_start_pc_i = 32'h20;
    trig_stop_pc_i  = 32'h24;
    do_reset();
    idle(1);
    check("armed_state", 136'(state_o), 136'h1);
    for (int pc = 'h1C; pc <= 'h28; pc++)
      retire(32'(pc), (pc >= 'h20 && pc <= 'h24));
    check("done_state", 136'(state_o), 136'h3);
    idle(3);
    trig_en_i = 1'b0;
    idle(1);
    check("done_to_idle", 136'(state_o), 136'h0);

    // 3: backpressure and overflow
    do_reset();
    dbg_ready_i = 1'b0;
    idle(1);
    for (int i = 0; i < 10; i++) retire(32'h100 + 32'(i), (i < 8));
    check("bp_level", 136'(level_o), 136'h8);
    check("bp_ovf", 136'(ovf_cnt_o), 136'h2);
    check("bp_head_hold", 136'(dbg_o[31:0]), 136'h100);
`ifdef TRACE_OVF_MARK_EN
    exp_q.push_back(mk_mark(16'd2));
`endif
    dbg_ready_i = 1'b1;
    idle(10);
    check("bp_drained", 136'(level_o), 136'h0);

    // 4: push and pop together while full
    dbg_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) retire(32'h200 + 32'(i), 1'b1);
    check("full_level", 136'(level_o), 136'h8);
    dbg_ready_i = 1'b1;
    retire(32'h208, 1'b1);
    check("full_pushpop_level", 136'(level_o), 136'h8);
    check("full_pushpop_ovf", 136'(ovf_cnt_o), 136'h2);
    idle(10);
    check("full_drained", 136'(level_o), 136'h0);

    // 5: reset in the middle of a drain
    dbg_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) retire(32'h300 + 32'(i), (i < 2));
    dbg_ready_i = 1'b1;
    idle(2);
    check("mid_level", 136'(level_o), 136'h5);
    dbg_ready_i = 1'b0;
    do_reset();
    check("mid_rst_valid", 136'(dbg_o[136]), 136'h0);
    check("mid_rst_level", 136'(level_o), 136'h0);
    check("mid_rst_ovf", 136'(ovf_cnt_o), 136'h0);
    check("mid_rst_state", 136'(state_o), 136'h0);

    // 6: overflow by 3 then drain; marker (when built in) precedes the next record
    idle(1);
    for (int i = 0; i < 11; i++) retire(32'h400 + 32'(i), (i < 8));
    check("ovf3_level", 136'(level_o), 136'h8);
    check("ovf3_cnt", 136'(ovf_cnt_o), 136'h3);
`ifdef TRACE_OVF_MARK_EN
    exp_q.push_back(mk_mark(16'd3));
`endif
    dbg_ready_i = 1'b1;
    idle(12);
    retire(32'h500, 1'b1);
    idle(3);
    check("final_level", 136'(level_o), 136'h0);
    check("final_queue", 136'(exp_q.size()), 136'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
